dmem_responder: RTL and testbench

//   Data-memory responder: the memory side of the load/store request interface.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_byte_ram.sv | 27 ++
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_WORD = 2'b10} dmem_size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam int unsigned DMEM_WORD_BYTES = 4;

  function automatic logic [DMEM_WORD_BYTES-1:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                       clk_i,
  input  logic [DMEM_WORD_BYTES-1:0] we_i,
  input  logic                       re_i,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < DMEM_WORD_BYTES; b++) begin
      if (we_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the load/store interface: request capture, wait-state FSM,
// error decode and byte-lane handling around a byte-writable RAM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [1:0]  size,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        error
);

  dmem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  is_read_q, is_byte_q, err_q;
  logic [ADDR_WIDTH-1:0] word_idx_q;
  logic [1:0]            lane_q;
  logic [31:0]           wdata_q, rdata_q;

  logic        req, req_err, accept, access;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata, ram_rdata, lane_shift, loaded, resp_data;

  assign req     = read_enable | write_enable;
  assign req_err = (read_enable & write_enable)
                 | ((size != SIZE_BYTE) && (size != SIZE_WORD))
                 | ((size == SIZE_WORD) && (address[1:0] != 2'b00))
                 | ((address >> (ADDR_WIDTH + 2)) != '0);
  assign accept  = (state_q == IDLE) && req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = WAIT;
        if (req_err)          cnt_d = '0;
        else if (read_enable) cnt_d = 4'(READ_LATENCY - 1);
        else                  cnt_d = 4'(WRITE_LATENCY - 1);
      end
      WAIT: if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 4'd1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_read_q  <= 1'b0;
      is_byte_q  <= 1'b0;
      err_q      <= 1'b0;
      word_idx_q <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        is_read_q  <= read_enable;
        is_byte_q  <= (size == SIZE_BYTE);
        err_q      <= req_err;
        word_idx_q <= address[ADDR_WIDTH+1:2];
        lane_q     <= address[1:0];
        wdata_q    <= write_data;
      end
      if (state_q == RESP) rdata_q <= resp_data;
    end
  end

  // Storage is touched only on the final WAIT edge, so the RAM's registered
  // read data lines up with the RESP cycle.
  assign access    = (state_q == WAIT) && (cnt_q == '0) && !err_q;
  assign ram_we    = (access && !is_read_q) ? (is_byte_q ? lane_mask(lane_q) : 4'hF) : 4'h0;
  assign ram_wdata = is_byte_q ? {4{wdata_q[7:0]}} : wdata_q;

  dmem_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (access && is_read_q),
    .addr_i  (word_idx_q),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign lane_shift = ram_rdata >> {lane_q, 3'b000};
  assign loaded     = is_byte_q ? {24'b0, lane_shift[7:0]} : ram_rdata;
  assign resp_data  = err_q ? '0 : (is_read_q ? loaded : rdata_q);

  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign error      = (state_q == RESP) && err_q;
  assign read_data  = (state_q == RESP) ? resp_data : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a default instance plus
// latency-sweep, busy-drop and mid-operation reset sequences.
module tb_dmem_responder;

  localparam int unsigned RLS [4] = '{2, 1, 4, 15};
  localparam int unsigned WLS [4] = '{1, 1, 1, 3};

  logic        clk = 1'b0;
  logic        rst [4];
  logic        re [4], we [4];
  logic [31:0] addr [4], wd [4];
  logic [1:0]  sz [4];
  logic        busy_s [4], rv [4], er [4];
  logic [31:0] rd [4];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(RLS[g]), .WRITE_LATENCY(WLS[g])) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .read_enable  (re[g]),
      .write_enable (we[g]),
      .address      (addr[g]),
      .size         (sz[g]),
      .write_data   (wd[g]),
      .busy         (busy_s[g]),
      .resp_valid   (rv[g]),
      .read_data    (rd[g]),
      .error        (er[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // Issues one request and follows it until busy drops; cycle t is sampled #1 after edge t-1.
  task automatic do_req(input int i, input logic r, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d, input bit late_wr,
                        output int rc, output int bc, output int nr,
                        output logic [31:0] data, output logic e);
    @(negedge clk);
    re[i] = r; we[i] = w; addr[i] = a; sz[i] = s; wd[i] = d;
    @(posedge clk); #1;
    re[i] = 1'b0; we[i] = 1'b0;
    if (late_wr) begin
      we[i] = 1'b1; sz[i] = 2'b10; wd[i] = 32'h5555_5555;
    end
    rc = 0; bc = 0; nr = 0; data = '0; e = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      if (t == 2) we[i] = 1'b0;
      if (rv[i]) begin
        if (rc == 0) rc = t;
        nr++;
        data = rd[i];
        e = er[i];
      end
      if (busy_s[i]) bc++;
      else break;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string       nm;
    bit          r, w;
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
    int          exp_rc;
    bit          exp_e;
    bit          chk_d;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vq[$];

  initial begin
    int rc, bc, nr, pulses;
    logic [31:0] data;
    logic e;

    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; re[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; sz[i] = 2'b10; wd[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    #1;
    chk("reset_busy", {31'b0, busy_s[0]}, 32'd0);
    chk("reset_resp_valid", {31'b0, rv[0]}, 32'd0);
    chk("reset_read_data", rd[0], 32'd0);
    chk("reset_error", {31'b0, er[0]}, 32'd0);

    vq.push_back('{"sw_0x10",     1'b0, 1'b1, 32'h10,        2'b10, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 32'h0});
    vq.push_back('{"lw_0x10",     1'b1, 1'b0, 32'h10,        2'b10, 32'h0,         3, 1'b0, 1'b1, 32'hDEAD_BEEF});
    vq.push_back('{"sw_0x20",     1'b0, 1'b1, 32'h20,        2'b10, 32'h1122_3344, 2, 1'b0, 1'b0, 32'h0});
    vq.push_back('{"sb_0x22",     1'b0, 1'b1, 32'h22,        2'b00, 32'hFFFF_FFAA, 2, 1'b0, 1'b0, 32'h0});
    vq.push_back('{"lbu_0x22",    1'b1, 1'b0, 32'h22,        2'b00, 32'h0,         3, 1'b0, 1'b1, 32'h0000_00AA});
    vq.push_back('{"lbu_0x23",    1'b1, 1'b0, 32'h23,        2'b00, 32'h0,         3, 1'b0, 1'b1, 32'h0000_0011});
    vq.push_back('{"lw_0x20",     1'b1, 1'b0, 32'h20,        2'b10, 32'h0,         3, 1'b0, 1'b1, 32'h11AA_3344});
    vq.push_back('{"lbu_0x20",    1'b1, 1'b0, 32'h20,        2'b00, 32'h0,         3, 1'b0, 1'b1, 32'h0000_0044});
    vq.push_back('{"lbu_0x21",    1'b1, 1'b0, 32'h21,        2'b00, 32'h0,         3, 1'b0, 1'b1, 32'h0000_0033});
    vq.push_back('{"err_lw_0x21", 1'b1, 1'b0, 32'h21,        2'b10, 32'h0,         2, 1'b1, 1'b1, 32'h0});
    vq.push_back('{"err_size01",  1'b1, 1'b0, 32'h20,        2'b01, 32'h0,         2, 1'b1, 1'b1, 32'h0});
    vq.push_back('{"err_size11",  1'b0, 1'b1, 32'h20,        2'b11, 32'h0,         2, 1'b1, 1'b1, 32'h0});
    vq.push_back('{"err_rw_both", 1'b1, 1'b1, 32'h20,        2'b10, 32'h0,         2, 1'b1, 1'b1, 32'h0});
    vq.push_back('{"err_sw_0x23", 1'b0, 1'b1, 32'h23,        2'b10, 32'h0,         2, 1'b1, 1'b1, 32'h0});
    vq.push_back('{"err_lw_oor",  1'b1, 1'b0, 32'h0001_0000, 2'b10, 32'h0,         2, 1'b1, 1'b1, 32'h0});
    vq.push_back('{"lw_0x20_kept",1'b1, 1'b0, 32'h20,        2'b10, 32'h0,         3, 1'b0, 1'b1, 32'h11AA_3344});
    vq.push_back('{"sw_0x0",      1'b0, 1'b1, 32'h0,         2'b10, 32'h0102_0304, 2, 1'b0, 1'b0, 32'h0});
    vq.push_back('{"err_sw_0x1000",1'b0,1'b1, 32'h1000,      2'b10, 32'hFFFF_FFFF, 2, 1'b1, 1'b1, 32'h0});
    vq.push_back('{"lw_0x0_noalias",1'b1,1'b0,32'h0,         2'b10, 32'h0,         3, 1'b0, 1'b1, 32'h0102_0304});
    vq.push_back('{"sw_0xFFC",    1'b0, 1'b1, 32'hFFC,       2'b10, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 32'h0});
    vq.push_back('{"lw_0xFFC",    1'b1, 1'b0, 32'hFFC,       2'b10, 32'h0,         3, 1'b0, 1'b1, 32'hCAFE_F00D});
    vq.push_back('{"lbu_0xFFF",   1'b1, 1'b0, 32'hFFF,       2'b00, 32'h0,         3, 1'b0, 1'b1, 32'h0000_00CA});

    foreach (vq[k]) begin
      do_req(0, vq[k].r, vq[k].w, vq[k].a, vq[k].s, vq[k].d, 1'b0, rc, bc, nr, data, e);
      chk({vq[k].nm, "_cycle"}, rc, vq[k].exp_rc);
      chk({vq[k].nm, "_busy"}, bc, vq[k].exp_rc);
      chk({vq[k].nm, "_npulse"}, nr, 1);
      chk({vq[k].nm, "_error"}, {31'b0, e}, {31'b0, vq[k].exp_e});
      if (vq[k].chk_d) chk({vq[k].nm, "_data"}, data, vq[k].exp_d);
    end
    #1 chk("hold_read_data", rd[0], 32'h0000_00CA);

    // Busy drop: a store presented during a load is ignored.
    do_req(0, 1'b1, 1'b0, 32'h10, 2'b10, 32'h0, 1'b1, rc, bc, nr, data, e);
    chk("drop_cycle", rc, 3);
    chk("drop_npulse", nr, 1);
    chk("drop_data", data, 32'hDEAD_BEEF);
    do_req(0, 1'b1, 1'b0, 32'h10, 2'b10, 32'h0, 1'b0, rc, bc, nr, data, e);
    chk("drop_word_kept", data, 32'hDEAD_BEEF);

    // Latency sweep on the other instances.
    for (int i = 1; i < 4; i++) begin
      do_req(i, 1'b0, 1'b1, 32'h40, 2'b10, 32'h0000_0001 + i, 1'b0, rc, bc, nr, data, e);
      chk($sformatf("sweep%0d_wr_cycle", i), rc, WLS[i] + 1);
      do_req(i, 1'b1, 1'b0, 32'h40, 2'b10, 32'h0, 1'b0, rc, bc, nr, data, e);
      chk($sformatf("sweep%0d_rd_cycle", i), rc, RLS[i] + 1);
      chk($sformatf("sweep%0d_rd_busy", i), bc, RLS[i] + 1);
      chk($sformatf("sweep%0d_rd_npulse", i), nr, 1);
      chk($sformatf("sweep%0d_rd_data", i), data, 32'h0000_0001 + i);
    end

    // Mid-operation reset: store aborted during WAIT on the WRITE_LATENCY=3 instance.
    @(negedge clk);
    we[3] = 1'b1; re[3] = 1'b0; addr[3] = 32'h40; sz[3] = 2'b10; wd[3] = 32'h0000_0099;
    @(posedge clk); #1;
    we[3] = 1'b0;
    @(posedge clk); #2;
    rst[3] = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy_s[3]}, 32'd0);
    chk("midrst_resp_valid", {31'b0, rv[3]}, 32'd0);
    chk("midrst_read_data", rd[3], 32'd0);
    chk("midrst_error", {31'b0, er[3]}, 32'd0);
    pulses = 0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      if (rv[3]) pulses++;
    end
    @(negedge clk);
    rst[3] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      if (rv[3]) pulses++;
    end
    chk("midrst_no_pulse", pulses, 0);
    do_req(3, 1'b1, 1'b0, 32'h40, 2'b10, 32'h0, 1'b0, rc, bc, nr, data, e);
    chk("midrst_old_data", data, 32'h0000_0004);
    chk("midrst_rd_cycle", rc, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
